// File: rtl/fp_mul_sequencer_if.sv
// Operand and result streams between the sequencer and its producer/consumer.
// The slave modport is the sequencer's view; the master modport is the peer's view.
interface fp_mul_sequencer_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_a_i;
  logic [31:0] in_b_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_product_o;
  logic [3:0]  out_flags_o;
  logic        out_timeout_o;

  modport slave (
    input  in_valid_i, in_a_i, in_b_i, out_ready_i,
    output in_ready_o, out_valid_o, out_product_o, out_flags_o, out_timeout_o
  );

  modport master (
    output in_valid_i, in_a_i, in_b_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_product_o, out_flags_o, out_timeout_o
  );
endinterface

// File: rtl/fp_mul_sequencer.sv
// Issue/collect controller for an FP32 multiplier: accepts one operand pair,
// pulses start, waits for a rising done (or a watchdog expiry), and holds the
// result until the consumer takes it. Counts completed and erroneous results.
module fp_mul_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  fp_mul_sequencer_if.slave  io,
  output logic [31:0]        mul_a_o,
  output logic [31:0]        mul_b_o,
  output logic               mul_start_o,
  input  logic               mul_done_i,
  input  logic [31:0]        mul_product_i,
  input  logic               mul_nan_i,
  input  logic               mul_inf_i,
  input  logic               mul_ovf_i,
  input  logic               mul_unf_i,
  output logic [CNT_W-1:0]   ops_count_o,
  output logic [CNT_W-1:0]   err_count_o
);

  localparam int               TMR_W           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST        = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      TIMEOUT_PRODUCT = 32'h7FC0_0000;
  localparam logic [3:0]       TIMEOUT_FLAGS   = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic               done_q_r;
  logic               done_rise_s;
  logic               accept_s;
  logic               capture_s;
  logic               expire_s;
  logic               out_fire_s;
  logic [TMR_W-1:0]   timer_r;
  logic [31:0]        out_product_r;
  logic [3:0]         out_flags_r;
  logic               out_timeout_r;
  logic               out_valid_r;
  logic [CNT_W-1:0]   ops_count_r;
  logic [CNT_W-1:0]   err_count_r;

  // A result counts as an error when any exception flag is set or the watchdog produced it.
  function automatic logic is_error(input logic [3:0] flags, input logic timeout);
    return (|flags) | timeout;
  endfunction

  // Next-state decode; a rising done in the expiry cycle takes priority over the watchdog.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    expire_s     = 1'b0;
    out_fire_s   = 1'b0;
    done_rise_s  = mul_done_i & ~done_q_r;
    case (state_r)
      ST_IDLE: begin
        if (io.in_valid_i) begin
          accept_s     = 1'b1;
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_rise_s) begin
          capture_s    = 1'b1;
          state_next_s = ST_HOLD;
        end else if (timer_r == TMR_LAST) begin
          expire_s     = 1'b1;
          state_next_s = ST_HOLD;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (out_valid_r && io.out_ready_i) begin
          out_fire_s   = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath: operand latch, done edge history, watchdog timer, result slot and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q_r      <= 1'b0;
      mul_a_o       <= 32'h0000_0000;
      mul_b_o       <= 32'h0000_0000;
      timer_r       <= {TMR_W{1'b0}};
      out_product_r <= 32'h0000_0000;
      out_flags_r   <= 4'b0000;
      out_timeout_r <= 1'b0;
      out_valid_r   <= 1'b0;
      ops_count_r   <= {CNT_W{1'b0}};
      err_count_r   <= {CNT_W{1'b0}};
    end else begin
      done_q_r <= mul_done_i;
      if (accept_s) begin
        mul_a_o <= io.in_a_i;
        mul_b_o <= io.in_b_i;
      end
      if (state_r == ST_ISSUE) begin
        timer_r <= {TMR_W{1'b0}};
      end else if (state_r == ST_WAIT) begin
        timer_r <= timer_r + TMR_W'(1);
      end
      if (capture_s) begin
        out_product_r <= mul_product_i;
        out_flags_r   <= {mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i};
        out_timeout_r <= 1'b0;
        out_valid_r   <= 1'b1;
      end else if (expire_s) begin
        out_product_r <= TIMEOUT_PRODUCT;
        out_flags_r   <= TIMEOUT_FLAGS;
        out_timeout_r <= 1'b1;
        out_valid_r   <= 1'b1;
      end else if (out_fire_s) begin
        out_valid_r <= 1'b0;
        ops_count_r <= ops_count_r + CNT_W'(1);
        if (is_error(out_flags_r, out_timeout_r) && (err_count_r != {CNT_W{1'b1}})) begin
          err_count_r <= err_count_r + CNT_W'(1);
        end
      end
    end
  end

  // Handshake and start strobes decode from state only (ready is also held low during reset).
  assign io.in_ready_o    = rst_n & (state_r == ST_IDLE);
  assign mul_start_o      = (state_r == ST_ISSUE);
  assign io.out_valid_o   = out_valid_r;
  assign io.out_product_o = out_product_r;
  assign io.out_flags_o   = out_flags_r;
  assign io.out_timeout_o = out_timeout_r;
  assign ops_count_o      = ops_count_r;
  assign err_count_o      = err_count_r;

endmodule

// File: tb/tb_fp_mul_sequencer.sv
// Scoreboard bench for fp_mul_sequencer: a behavioural multiplier stub answers
// each start after a chosen latency (or never), expected results are queued
// and a monitor compares every presented result and the counters.
module tb_fp_mul_sequencer;
  localparam int TMO   = 8;
  localparam int CNT_W = 16;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
    logic [3:0]  flags;
    int          k;      // >0 done latency, 0 never answer, <0 abandoned by reset
    bit          alt;    // stale done pulse (k==0) or 2-cycle done (k>0)
  } op_t;

  typedef struct {
    logic [31:0] prod;
    logic [3:0]  flags;
    logic        tmo;
  } res_t;

  logic              clk;
  logic              rst_n;
  logic [31:0]       mul_a;
  logic [31:0]       mul_b;
  logic              mul_start;
  logic              mul_done;
  logic [31:0]       mul_product;
  logic [3:0]        mul_flags;
  logic [CNT_W-1:0]  ops_count;
  logic [CNT_W-1:0]  err_count;

  op_t               op_q[$];
  res_t              exp_q[$];
  logic [CNT_W-1:0]  exp_ops;
  logic [CNT_W-1:0]  exp_err;
  int                checks;
  int                errors;
  int                ready_force;

  fp_mul_sequencer_if bus ();

  fp_mul_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .io            (bus),
    .mul_a_o       (mul_a),
    .mul_b_o       (mul_b),
    .mul_start_o   (mul_start),
    .mul_done_i    (mul_done),
    .mul_product_i (mul_product),
    .mul_nan_i     (mul_flags[3]),
    .mul_inf_i     (mul_flags[2]),
    .mul_ovf_i     (mul_flags[1]),
    .mul_unf_i     (mul_flags[0]),
    .ops_count_o   (ops_count),
    .err_count_o   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endfunction

  // Multiplier reference: known IEEE cases, otherwise an arbitrary result the stub returns.
  function automatic void mul_ref(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] p, output logic [3:0] f);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) begin
      p = 32'h4000_0000; f = 4'b0000;
    end else if (a == 32'h7F80_0000 && b == 32'h0000_0000) begin
      p = 32'h7FC0_0000; f = 4'b1000;
    end else begin
      p = $urandom;
      f = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
    end
  endfunction

  task automatic send_op(input logic [31:0] a, input logic [31:0] b, input int k,
                         input bit alt, input int force_low);
    op_t op;
    int  n;
    op.a = a; op.b = b; op.k = k; op.alt = alt;
    mul_ref(a, b, op.prod, op.flags);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b1; bus.in_a_i = a; bus.in_b_i = b;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready_o) begin
      check_eq("accept_wait_expired", 32'd0, 32'd1);
      bus.in_valid_i = 1'b0;
    end else begin
      op_q.push_back(op);
      if (force_low > 0) ready_force = force_low;
      @(posedge clk); #1;
      bus.in_valid_i = 1'b0; bus.in_a_i = $urandom; bus.in_b_i = $urandom;
      @(negedge clk);
      check_eq("start_after_accept", {31'd0, mul_start}, 32'd1);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || op_q.size() != 0 || !bus.in_ready_o || bus.out_valid_o) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_idle", {31'd0, bus.in_ready_o}, 32'd1);
  endtask

  // Multiplier stub: reacts to start, checks operands and pulse shape, returns a result.
  initial begin : mul_stub
    op_t  op;
    res_t r;
    mul_done = 1'b0; mul_product = 32'h0; mul_flags = 4'b0000;
    forever begin
      @(negedge clk);
      if (rst_n && mul_start) begin
        if (op_q.size() == 0) begin
          check_eq("start_unexpected", 32'd1, 32'd0);
        end else begin
          op = op_q.pop_front();
          check_eq("mul_a", mul_a, op.a);
          check_eq("mul_b", mul_b, op.b);
          if (op.k == 0) begin
            r.prod = 32'h7FC0_0000; r.flags = 4'b1000; r.tmo = 1'b1;
            exp_q.push_back(r);
            if (op.alt) begin
              mul_done = 1'b1; mul_product = $urandom; mul_flags = 4'b0101;
            end
            @(negedge clk);
            check_eq("start_pulse_width", {31'd0, mul_start}, 32'd0);
            mul_done = 1'b0;
            repeat (TMO - 1) @(negedge clk);
            check_eq("tmo_not_early", {31'd0, bus.out_valid_o}, 32'd0);
            @(negedge clk);
            check_eq("tmo_latency", {31'd0, bus.out_valid_o}, 32'd1);
          end else if (op.k > 0) begin
            @(negedge clk);
            check_eq("start_pulse_width", {31'd0, mul_start}, 32'd0);
            repeat (op.k - 1) @(negedge clk);
            check_eq("valid_not_early", {31'd0, bus.out_valid_o}, 32'd0);
            mul_product = op.prod; mul_flags = op.flags; mul_done = 1'b1;
            r.prod = op.prod; r.flags = op.flags; r.tmo = 1'b0;
            exp_q.push_back(r);
            @(negedge clk);
            check_eq("done_to_valid", {31'd0, bus.out_valid_o}, 32'd1);
            check_eq("mul_a_stable", mul_a, op.a);
            if (op.alt) @(negedge clk);
            mul_done = 1'b0; mul_product = $urandom; mul_flags = 4'($urandom);
          end
        end
      end
    end
  end

  // Consumer: random back-pressure, with an optional forced-low stretch.
  initial begin : consumer
    bus.out_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ready_force > 0) begin
        bus.out_ready_i = 1'b0;
        ready_force--;
      end else begin
        bus.out_ready_i = ($urandom_range(0, 2) != 0);
      end
    end
  end

  // Monitor: compares every presented result against the queue head and the counters after each handshake.
  initial begin : monitor
    res_t e;
    bit   cnt_pending;
    cnt_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (cnt_pending && rst_n) begin
        check_eq("ops_count", 32'(ops_count), 32'(exp_ops));
        check_eq("err_count", 32'(err_count), 32'(exp_err));
        check_eq("ready_after_handshake", {31'd0, bus.in_ready_o}, 32'd1);
        cnt_pending = 1'b0;
      end
      if (rst_n && bus.out_valid_o) begin
        check_eq("hold_in_ready", {31'd0, bus.in_ready_o}, 32'd0);
        check_eq("hold_no_start", {31'd0, mul_start}, 32'd0);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q[0];
          check_eq("out_product", bus.out_product_o, e.prod);
          check_eq("out_flags", {28'd0, bus.out_flags_o}, {28'd0, e.flags});
          check_eq("out_timeout", {31'd0, bus.out_timeout_o}, {31'd0, e.tmo});
          if (bus.out_ready_i) begin
            void'(exp_q.pop_front());
            exp_ops = exp_ops + CNT_W'(1);
            if (((|e.flags) || e.tmo) && exp_err != {CNT_W{1'b1}}) exp_err = exp_err + CNT_W'(1);
            cnt_pending = 1'b1;
          end
        end
      end
    end
  end

  initial begin : driver
    logic [31:0] a;
    logic [31:0] b;
    int          k;
    checks = 0; errors = 0; ready_force = 0;
    exp_ops = '0; exp_err = '0;
    rst_n = 1'b0;
    bus.in_valid_i = 1'b0; bus.in_a_i = 32'h0; bus.in_b_i = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", {31'd0, bus.in_ready_o}, 32'd0);
    check_eq("rst_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
    check_eq("rst_start", {31'd0, mul_start}, 32'd0);
    check_eq("rst_mul_a", mul_a, 32'd0);
    check_eq("rst_ops", 32'(ops_count), 32'd0);
    check_eq("rst_err", 32'(err_count), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_in_ready", {31'd0, bus.in_ready_o}, 32'd1);

    // Directed: 1.0*2.0, inf*0 with a long stall in HOLD, stale-pulse timeout, expiry-cycle done, plain timeout.
    send_op(32'h3F80_0000, 32'h4000_0000, 3, 1'b0, 0);
    send_op(32'h7F80_0000, 32'h0000_0000, 2, 1'b0, 16);
    send_op(32'h1234_5678, 32'h8765_4321, 0, 1'b1, 0);
    send_op(32'h4040_0000, 32'h4080_0000, TMO, 1'b1, 0);
    send_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 1'b0, 0);
    wait_idle();

    // Reset while the multiplier is being waited on.
    send_op(32'hCAFE_F00D, 32'h1357_9BDF, -1, 1'b0, 0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_eq("midop_rst_ready_low", {31'd0, bus.in_ready_o}, 32'd0);
    @(posedge clk); #1;
    exp_ops = '0; exp_err = '0;
    @(negedge clk);
    check_eq("midop_rst_valid", {31'd0, bus.out_valid_o}, 32'd0);
    check_eq("midop_rst_ops", 32'(ops_count), 32'd0);
    check_eq("midop_rst_err", 32'(err_count), 32'd0);
    check_eq("midop_rst_ready", {31'd0, bus.in_ready_o}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("midop_rst_idle", {31'd0, bus.in_ready_o}, 32'd1);
    repeat (TMO + 4) @(negedge clk);
    check_eq("midop_rst_no_result", {31'd0, bus.out_valid_o}, 32'd0);

    // Random operations with random latency, timeouts and back-pressure.
    for (int i = 0; i < 60; i++) begin
      a = $urandom; b = $urandom;
      k = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, TMO));
      send_op(a, b, k, 1'($urandom_range(0, 1)), 0);
    end
    wait_idle();
    @(negedge clk);
    check_eq("ops_final", 32'(ops_count), 32'd60);
    check_eq("err_final", 32'(err_count), 32'(exp_err));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL global_timeout actual=%0d required=0", 1);
    $fatal(1, "bench timed out");
  end
endmodule
